// File: rtl/present80_ctrl_if.sv
// rtl/present80_ctrl_if.sv - handshake and round-control bundle for present80_ctrl (abt only with PRESENT80_CTRL_ABORT_EN)
interface present80_ctrl_if #(
    parameter int RW = 5
);
    logic          in_vld;
    logic          in_rdy;
    logic          out_vld;
    logic          out_rdy;
    logic          sta;
    logic          act;
    logic [RW-1:0] rnd;
    logic          lst;
`ifdef PRESENT80_CTRL_ABORT_EN
    logic          abt;
`endif

    modport master (
`ifdef PRESENT80_CTRL_ABORT_EN
        input  abt,
`endif
        input  in_vld,
        input  out_rdy,
        output in_rdy,
        output out_vld,
        output sta,
        output act,
        output rnd,
        output lst
    );

    modport slave (
`ifdef PRESENT80_CTRL_ABORT_EN
        output abt,
`endif
        output in_vld,
        output out_rdy,
        input  in_rdy,
        input  out_vld,
        input  sta,
        input  act,
        input  rnd,
        input  lst
    );
endinterface

// File: rtl/present80_ctrl.sv
// rtl/present80_ctrl.sv - PRESENT-80 round controller: IDLE/RUN/DONE sequencing of NR rounds per block
// Optional abort input built when PRESENT80_CTRL_ABORT_EN is defined.
module present80_ctrl #(
    parameter int NR = 31,
    parameter int RW = 5
) (
    input  logic             ck,
    input  logic             rst,
    present80_ctrl_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [RW-1:0] RND_ZERO  = '0;
    localparam logic [RW-1:0] RND_FIRST = RW'(1);
    localparam logic [RW-1:0] RND_LAST  = RW'(NR);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [RW-1:0] rnd_q;
    logic [RW-1:0] rnd_nxt;
    logic          abort;
    logic          in_rdy;
    logic          sta;
    logic          at_last;

`ifdef PRESENT80_CTRL_ABORT_EN
    assign abort = bus.abt & (state != IDLE);
`else
    assign abort = 1'b0;
`endif

    assign at_last = (rnd_q == RND_LAST);
    // DONE with out_rdy hands the state register straight to the next block
    assign in_rdy  = ((state == IDLE) | ((state == DONE) & bus.out_rdy)) & ~abort;
    assign sta     = bus.in_vld & in_rdy;

    always_comb begin
        state_nxt = state;
        rnd_nxt   = rnd_q;
        if (abort) begin
            state_nxt = IDLE;
            rnd_nxt   = RND_ZERO;
        end else if (sta) begin
            state_nxt = RUN;
            rnd_nxt   = RND_FIRST;
        end else begin
            case (state)
                IDLE: state_nxt = IDLE;
                RUN: begin
                    if (at_last) begin
                        state_nxt = DONE;
                    end else begin
                        rnd_nxt = rnd_q + RND_FIRST;
                    end
                end
                DONE: begin
                    if (bus.out_rdy) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rnd_q <= RND_ZERO;
        end else begin
            state <= state_nxt;
            rnd_q <= rnd_nxt;
        end
    end

    assign bus.in_rdy  = in_rdy;
    assign bus.sta     = sta;
    assign bus.act     = (state == RUN);
    assign bus.lst     = (state == RUN) & at_last;
    assign bus.out_vld = (state == DONE);
    assign bus.rnd     = rnd_q;
endmodule

// File: tb/tb_present80_ctrl.sv
// tb/tb_present80_ctrl.sv - self-checking bench for present80_ctrl (NR=31), abort cases with PRESENT80_CTRL_ABORT_EN
module tb_present80_ctrl;
    localparam int NR = 31;
    localparam int RW = 5;

    logic ck = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 ck = ~ck;

    present80_ctrl_if #(.RW(RW)) bus ();

    present80_ctrl #(.NR(NR), .RW(RW)) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    // Model: age of the block in flight counted in edges since acceptance.
    // 0 = nothing in flight, 1..NR = round being computed, NR+1 = ciphertext waiting.
    int   m_age  = 0;
    int   m_last = 0;
    logic e_run, e_done, e_abort, e_in_rdy, e_sta, e_lst;
    int   e_rnd;

    always_comb begin
        e_run   = (m_age >= 1) && (m_age <= NR);
        e_done  = (m_age > NR);
`ifdef PRESENT80_CTRL_ABORT_EN
        e_abort = (bus.abt === 1'b1) && (m_age != 0);
`else
        e_abort = 1'b0;
`endif
        e_in_rdy = ((m_age == 0) || (e_done && bus.out_rdy === 1'b1)) && !e_abort;
        e_sta    = e_in_rdy && (bus.in_vld === 1'b1);
        e_lst    = (m_age == NR);
        e_rnd    = (m_age == 0) ? m_last : (e_run ? m_age : NR);
    end

    always @(posedge ck or posedge rst) begin
        if (rst) begin
            m_age  <= 0;
            m_last <= 0;
        end else if (e_abort) begin
            m_age  <= 0;
            m_last <= 0;
        end else if (e_sta) begin
            m_age <= 1;
        end else if (e_run) begin
            m_age <= m_age + 1;
        end else if (e_done && bus.out_rdy === 1'b1) begin
            m_age  <= 0;
            m_last <= NR;
        end
    end

    always @(negedge ck) begin
        chk("m_in_rdy",  32'(bus.in_rdy),  32'(e_in_rdy));
        chk("m_sta",     32'(bus.sta),     32'(e_sta));
        chk("m_act",     32'(bus.act),     32'(e_run));
        chk("m_lst",     32'(bus.lst),     32'(e_lst));
        chk("m_out_vld", 32'(bus.out_vld), 32'(e_done));
        chk("m_rnd",     32'(bus.rnd),     32'(e_rnd));
    end

    int act_cnt;
    int lst_cnt;

    initial begin
        rst         = 1'b1;
        bus.in_vld  = 1'b1;
        bus.out_rdy = 1'b0;
`ifdef PRESENT80_CTRL_ABORT_EN
        bus.abt     = 1'b0;
`endif
        repeat (3) @(posedge ck);
        #1;
        chk("rst_in_rdy",  32'(bus.in_rdy),  32'd1);
        chk("rst_sta",     32'(bus.sta),     32'd1);
        chk("rst_act",     32'(bus.act),     32'd0);
        chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
        chk("rst_rnd",     32'(bus.rnd),     32'd0);
        chk("rst_lst",     32'(bus.lst),     32'd0);

        // single block, accepted at the first edge after reset release
        rst = 1'b0;
        #1;
        chk("b1_sta", 32'(bus.sta), 32'd1);
        tick();
        bus.in_vld = 1'b0;
        act_cnt = 0;
        lst_cnt = 0;
        for (int i = 1; i <= NR; i++) begin
            chk("b1_rnd", 32'(bus.rnd), 32'(i));
            chk("b1_lst", 32'(bus.lst), 32'(i == NR));
            chk("b1_vld", 32'(bus.out_vld), 32'd0);
            act_cnt += int'(bus.act);
            lst_cnt += int'(bus.lst);
            tick();
        end
        chk("b1_act_cycles", 32'(act_cnt), 32'd31);
        chk("b1_lst_cycles", 32'(lst_cnt), 32'd1);
        chk("b1_out_vld_edge31", 32'(bus.out_vld), 32'd1);

        // backpressure in DONE, with in_vld pushing
        bus.in_vld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_out_vld", 32'(bus.out_vld), 32'd1);
            chk("bp_rnd",     32'(bus.rnd),     32'd31);
            chk("bp_act",     32'(bus.act),     32'd0);
            chk("bp_in_rdy",  32'(bus.in_rdy),  32'd0);
            tick();
        end

        // back-to-back acceptance, then in_vld held high through RUN
        bus.out_rdy = 1'b1;
        #1;
        chk("b2b_sta",    32'(bus.sta),    32'd1);
        chk("b2b_in_rdy", 32'(bus.in_rdy), 32'd1);
        tick();
        bus.out_rdy = 1'b0;
        chk("b2b_act", 32'(bus.act), 32'd1);
        chk("b2b_rnd", 32'(bus.rnd), 32'd1);
        for (int i = 1; i <= NR; i++) begin
            chk("ign_sta", 32'(bus.sta), 32'd0);
            chk("ign_rnd", 32'(bus.rnd), 32'(i));
            tick();
        end
        chk("ign_done", 32'(bus.out_vld), 32'd1);
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b1;
        tick();
        chk("idle_in_rdy",  32'(bus.in_rdy),  32'd1);
        chk("idle_out_vld", 32'(bus.out_vld), 32'd0);
        chk("idle_rnd",     32'(bus.rnd),     32'd31);
        tick();

        // asynchronous reset mid-RUN at round 12
        bus.in_vld = 1'b1;
        tick();
        bus.in_vld = 1'b0;
        repeat (11) tick();
        chk("mid_rnd12", 32'(bus.rnd), 32'd12);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_act",     32'(bus.act),     32'd0);
        chk("arst_out_vld", 32'(bus.out_vld), 32'd0);
        chk("arst_rnd",     32'(bus.rnd),     32'd0);
        chk("arst_in_rdy",  32'(bus.in_rdy),  32'd1);
        tick();
        rst = 1'b0;
        tick();

`ifdef PRESENT80_CTRL_ABORT_EN
        bus.in_vld = 1'b1;
        tick();
        bus.in_vld = 1'b0;
        repeat (19) tick();
        chk("abt_rnd20", 32'(bus.rnd), 32'd20);
        bus.abt    = 1'b1;
        bus.in_vld = 1'b1;
        #1;
        chk("abt_in_rdy", 32'(bus.in_rdy), 32'd0);
        chk("abt_sta",    32'(bus.sta),    32'd0);
        tick();
        chk("abt_rnd0",       32'(bus.rnd),     32'd0);
        chk("abt_act",        32'(bus.act),     32'd0);
        chk("abt_out_vld",    32'(bus.out_vld), 32'd0);
        chk("abt_idle_rdy",   32'(bus.in_rdy),  32'd1);
        chk("abt_idle_sta",   32'(bus.sta),     32'd1);
        tick();
        chk("abt_idle_ign", 32'(bus.rnd), 32'd1);
        bus.abt    = 1'b0;
        bus.in_vld = 1'b0;
        repeat (30) tick();
        chk("abt_last_lst", 32'(bus.lst), 32'd1);
        bus.abt = 1'b1;
        tick();
        chk("abt_last_vld", 32'(bus.out_vld), 32'd0);
        chk("abt_last_rnd", 32'(bus.rnd),     32'd0);
        bus.abt = 1'b0;
        tick();
`endif

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
